// File: rtl/ecp5pll_phase_pkg.sv
// Shared encodings for the ECP5 PLL dynamic phase controller.
package ecp5pll_phase_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STEP,
    ST_HOLD,
    ST_SETTLE
  } step_state_t;

  typedef enum logic [2:0] {
    SW_IDLE,
    SW_SCORE,
    SW_NEXT,
    SW_WAIT,
    SW_CENTER
  } sweep_state_t;

  localparam logic DIR_INC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

  function automatic int phase_width(input int steps);
    return (steps > 2) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/ecp5pll_phase_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser followed by a stability down-counter.
module btn_debounce #(
  parameter int C_bits = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db
);

  logic [1:0]        sync;
  logic [C_bits-1:0] cnt;

  // The output flips only after 2^C_bits consecutive samples that disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      cnt  <= '1;
      db   <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == db) begin
        cnt <= '1;
      end else if (cnt == '0) begin
        db  <= sync[1];
        cnt <= '1;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ecp5pll_phase_ctrl.sv
// Multi-channel EHXPLLL dynamic phase stepper with button control and
// an auto-sweep that centres a channel in its widest error-free window.
//
// step FSM  | meaning
// ST_IDLE   | waiting for a manual or sweep step request
// ST_SETUP  | phasesel/phasedir latched, one cycle ahead of the pulse
// ST_STEP   | phasestep high for C_step_hold cycles
// ST_HOLD   | phasestep low, sel/dir still held
// ST_SETTLE | C_settle cycles for the PLL to settle
//
// sweep FSM | meaning
// SW_IDLE   | no sweep running
// SW_SCORE  | counting pass/fail events at the current position
// SW_NEXT   | fold position result into runs, request +1 step
// SW_WAIT   | wait for the step to finish, then score or wrap up
// SW_CENTER | walk back with -1 steps to the window centre
module ecp5pll_phase_ctrl
  import ecp5pll_phase_pkg::*;
#(
  parameter int C_channels      = 2,
  parameter int C_steps         = 64,
  parameter int C_debounce_bits = 16,
  parameter int C_step_hold     = 4,
  parameter int C_settle        = 1024,
  parameter int C_passes        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic [1:0] sel,
  input  logic       sweep_start,
  input  logic       pass_in,
  input  logic       fail_in,
  output logic [1:0] phasesel,
  output logic       phasedir,
  output logic       phasestep,
  output logic       phaseloadreg,
  output logic [7:0] phase,
  output logic       busy,
  output logic       sweep_done,
  output logic       sweep_fail,
  output logic [7:0] win_lo,
  output logic [7:0] win_len
);

  localparam int PW   = phase_width(C_steps);
  localparam int TMAX = (C_settle > C_step_hold) ? C_settle : C_step_hold;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = $clog2(C_passes + 1);

  localparam logic [TW-1:0] HOLD_LD   = TW'(C_step_hold - 1);
  localparam logic [TW-1:0] SETTLE_LD = TW'(C_settle - 1);
  localparam logic [CW-1:0] PASS_LAST = CW'(C_passes - 1);
  localparam logic [PW:0]   N_POS     = (PW + 1)'(C_steps);
  localparam logic [PW:0]   LEN_MAX   = (PW + 1)'(255);

  step_state_t  st_state, st_next;
  sweep_state_t sw_state, sw_next;

  logic          inc_db, dec_db, inc_db_q, dec_db_q;
  logic          inc_rise, dec_rise, sel_ok;
  logic          man_go, man_dir, sw_req, sw_dir, sw_begin, sw_end;
  logic [TW-1:0] tmr;
  logic [PW-1:0] phase_cnt [C_channels];
  logic [PW-1:0] sw_phase, sel_phase, target;

  logic [1:0]    sw_chan;
  logic [PW:0]   pos_cnt, cur_len, best_len, run_len;
  logic [CW-1:0] pass_cnt;
  logic          pos_bad;
  logic [PW-1:0] cur_lo, best_lo, run_lo;

  btn_debounce #(.C_bits(C_debounce_bits)) u_db_inc (
    .clk(clk), .rst_n(rst_n), .raw(inc), .db(inc_db)
  );
  btn_debounce #(.C_bits(C_debounce_bits)) u_db_dec (
    .clk(clk), .rst_n(rst_n), .raw(dec), .db(dec_db)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_db_q <= 1'b0;
      dec_db_q <= 1'b0;
    end else begin
      inc_db_q <= inc_db;
      dec_db_q <= dec_db;
    end
  end

  assign inc_rise     = inc_db & ~inc_db_q;
  assign dec_rise     = dec_db & ~dec_db_q;
  assign sel_ok       = (int'(sel) < C_channels);
  assign busy         = (st_state != ST_IDLE) || (sw_state != SW_IDLE);
  assign phasestep    = (st_state == ST_STEP);
  assign phaseloadreg = 1'b0;
  assign phase        = 8'(sel_phase);

  always_comb begin
    sw_phase  = '0;
    sel_phase = '0;
    for (int i = 0; i < C_channels; i++) begin
      if (sw_chan == 2'(i)) sw_phase = phase_cnt[i];
      if (sel == 2'(i))     sel_phase = phase_cnt[i];
    end
  end

  always_comb begin
    man_go  = 1'b0;
    man_dir = DIR_INC;
    if (!busy && sel_ok && !(inc_db && dec_db)) begin
      if (inc_rise) begin
        man_go = 1'b1;
      end else if (dec_rise) begin
        man_go  = 1'b1;
        man_dir = DIR_DEC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_state <= ST_IDLE;
    else        st_state <= st_next;
  end

  always_comb begin
    st_next = st_state;
    case (st_state)
      ST_IDLE:   if (sw_req || man_go) st_next = ST_SETUP;
      ST_SETUP:  st_next = ST_STEP;
      ST_STEP:   if (tmr == '0) st_next = ST_HOLD;
      ST_HOLD:   st_next = ST_SETTLE;
      ST_SETTLE: if (tmr == '0) st_next = ST_IDLE;
      default:   st_next = ST_IDLE;
    endcase
  end

  // Counter moves as the pulse starts so 'phase' tracks the PLL from the first STEP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phasesel <= '0;
      phasedir <= DIR_INC;
      tmr      <= '0;
      for (int i = 0; i < C_channels; i++) phase_cnt[i] <= '0;
    end else begin
      case (st_state)
        ST_IDLE: begin
          if (sw_req) begin
            phasesel <= sw_chan;
            phasedir <= sw_dir;
          end else if (man_go) begin
            phasesel <= sel;
            phasedir <= man_dir;
          end
        end
        ST_SETUP:  tmr <= HOLD_LD;
        ST_HOLD:   tmr <= SETTLE_LD;
        ST_STEP,
        ST_SETTLE: if (tmr != '0) tmr <= tmr - 1'b1;
        default: ;
      endcase
      if (st_state == ST_SETUP) begin
        for (int i = 0; i < C_channels; i++) begin
          if (phasesel == 2'(i))
            phase_cnt[i] <= (phasedir == DIR_DEC) ? phase_cnt[i] - 1'b1 : phase_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign run_len = cur_len + 1'b1;
  assign run_lo  = (cur_len == '0) ? sw_phase : cur_lo;
  assign target  = best_lo + PW'((best_len - 1'b1) >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sw_state <= SW_IDLE;
    else        sw_state <= sw_next;
  end

  always_comb begin
    sw_next  = sw_state;
    sw_req   = 1'b0;
    sw_dir   = DIR_INC;
    sw_begin = 1'b0;
    sw_end   = 1'b0;
    case (sw_state)
      SW_IDLE: begin
        if (sweep_start && !busy && sel_ok) begin
          sw_begin = 1'b1;
          sw_next  = SW_SCORE;
        end
      end
      SW_SCORE: if (pass_in && pass_cnt == PASS_LAST) sw_next = SW_NEXT;
      SW_NEXT: begin
        sw_req  = 1'b1;
        sw_next = SW_WAIT;
      end
      SW_WAIT: begin
        if (st_state == ST_IDLE) begin
          if (pos_cnt != N_POS) begin
            sw_next = SW_SCORE;
          end else if (best_len == '0) begin
            sw_end  = 1'b1;
            sw_next = SW_IDLE;
          end else begin
            sw_next = SW_CENTER;
          end
        end
      end
      SW_CENTER: begin
        if (st_state == ST_IDLE) begin
          if (sw_phase == target) begin
            sw_end  = 1'b1;
            sw_next = SW_IDLE;
          end else begin
            sw_req = 1'b1;
            sw_dir = DIR_DEC;
          end
        end
      end
      default: sw_next = SW_IDLE;
    endcase
  end

  // Strict '>' on the best run keeps the earliest window on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_chan    <= '0;
      pos_cnt    <= '0;
      pass_cnt   <= '0;
      pos_bad    <= 1'b0;
      cur_lo     <= '0;
      cur_len    <= '0;
      best_lo    <= '0;
      best_len   <= '0;
      sweep_done <= 1'b0;
      sweep_fail <= 1'b0;
      win_lo     <= '0;
      win_len    <= '0;
    end else begin
      if (sw_begin) begin
        sw_chan    <= sel;
        pos_cnt    <= '0;
        pass_cnt   <= '0;
        pos_bad    <= 1'b0;
        cur_lo     <= '0;
        cur_len    <= '0;
        best_lo    <= '0;
        best_len   <= '0;
        sweep_done <= 1'b0;
        sweep_fail <= 1'b0;
      end
      if (sw_state == SW_SCORE) begin
        if (pass_in) pass_cnt <= pass_cnt + 1'b1;
        if (fail_in) pos_bad  <= 1'b1;
      end
      if (sw_state == SW_NEXT) begin
        pass_cnt <= '0;
        pos_bad  <= 1'b0;
        pos_cnt  <= pos_cnt + 1'b1;
        if (pos_bad) begin
          cur_len <= '0;
        end else begin
          cur_len <= run_len;
          cur_lo  <= run_lo;
          if (run_len > best_len) begin
            best_len <= run_len;
            best_lo  <= run_lo;
          end
        end
      end
      if (sw_end) begin
        sweep_done <= 1'b1;
        sweep_fail <= (best_len == '0);
        win_lo     <= 8'(best_lo);
        win_len    <= (best_len > LEN_MAX) ? 8'hFF : 8'(best_len);
      end
    end
  end

endmodule

// File: doc/ecp5pll_phase_ctrl.md
# ecp5pll_phase_ctrl

Multi-channel ECP5 PLL dynamic phase controller, successor to the single-channel debounced button phase stepper. Drives EHXPLLL PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG for up to 4 outputs and keeps a modulo phase count per channel. Supports manual inc/dec stepping from buttons, plus an auto-sweep mode. Auto-sweep scans a selected channel through one full turn, scores each position from memory-tester pass/fail events, and parks the channel at the centre of the widest error-free window. Sits between the buttons/mem_tester and the SDRAM-clock PLL in memtest tops.

## Interface
- C_channels, 2, number of phase-controlled PLL outputs (1..4)
- C_steps, 64, phase steps per full output-clock turn (power of 2, 8..256)
- C_debounce_bits, 16, debounce counter width
- C_step_hold, 4, cycles phasestep is held high (>=2)
- C_settle, 1024, cycles between consecutive PLL steps
- C_passes, 4, pass_in pulses required to score one sweep position
- clk  in  1  controller clock; all I/O synchronous to it
- rst_n  in  1  asynchronous active-low reset
- inc, dec  in  1  raw buttons, active high, asynchronous to clk
- sel  in  2  channel for manual steps and sweep; values >= C_channels ignored
- sweep_start  in  1  single-cycle pulse, starts auto-sweep on sel
- pass_in, fail_in  in  1  single-cycle event pulses from mem_tester
- phasesel  out  2  to PLL PHASESEL
- phasedir  out  1  to PLL PHASEDIR (0 = increment)
- phasestep  out  1  to PLL PHASESTEP, active-high pulse
- phaseloadreg  out  1  to PLL PHASELOADREG, constant 0
- phase  out  8  phase count of sel channel, zero-extended
- busy  out  1  step or sweep in progress
- sweep_done, sweep_fail  out  1  sticky; cleared by next sweep_start
- win_lo, win_len  out  8  last sweep window start and length

## Operation
- Phase counters: one per channel, width log2(C_steps). Increment/decrement modulo C_steps on each issued step: C_steps-1 +1 -> 0, 0 -1 -> C_steps-1.
- Debounce: 2-FF synchroniser, then the output changes only after 2^C_debounce_bits stable cycles. The rising edge of debounced inc/dec queues one step on sel.
- Manual steps are ignored while busy. Manual steps are also ignored when inc and dec are both debounced-high.
- Step FSM:
  - IDLE -> SETUP: latch phasesel and phasedir.
  - SETUP (1 cycle) -> STEP: phasestep=1 for C_step_hold cycles. The counter updates on entry to STEP.
  - STEP -> HOLD (1 cycle, phasestep=0, sel/dir held) -> SETTLE (C_settle cycles) -> IDLE.
- Sweep FSM:
  - SW_IDLE -> SW_SCORE on sweep_start. sweep_start is ignored if busy.
  - SW_SCORE: count pass_in. Any fail_in marks the position bad. Events arriving during SETTLE are discarded.
  - After C_passes passes -> SW_NEXT: update the current run and the best run, then issue +1 step. Repeat until C_steps positions are scored and the channel has returned to its start phase.
  - SW_CENTER: issue -1 steps until phase = win_lo + (win_len-1)/2 (mod C_steps) -> SW_IDLE, sweep_done=1.
- Window scoring:
  - Windows are measured in position order starting from the start phase. Wrap-around runs are not merged.
  - Ties keep the earlier window.
  - All positions bad: win_len=0, sweep_fail=1, sweep_done=1, channel left at its start phase.
- Simultaneous pass_in and fail_in: the fail wins and the pass is still counted.

## Timing
- Reset values: all counters 0; phasestep=0, phasedir=0, phasesel=0, phaseloadreg=0; busy=0; sweep flags 0; win_lo=0, win_len=0.
- Button press to phasestep rising edge: debounce time + 2 sync + 1 SETUP cycle.
- phasesel and phasedir are stable from 1 cycle before phasestep rises until 1 cycle after it falls.
- Step period: C_step_hold+2+C_settle cycles, so consecutive steps on one channel are at least this far apart.
- phase changes on the first STEP cycle. busy is high from SETUP through the end of SETTLE, and through the whole sweep.
- Reset mid-operation clears everything immediately; phasestep drops asynchronously. rst_n must accompany the PLL reset, otherwise the counters desynchronise from the PLL.

## Structure
- Package ecp5pll_phase_pkg holds the FSM state encodings, the phase-width function log2(C_steps), and the phasedir encoding constants.
- One sub-module, btn_debounce (sync + counter, one instance per button).
- Both FSMs live in the top module; the per-channel counters are an array.

## Test plan
- C_debounce_bits=4: inc held 40 cycles -> exactly one phasestep pulse of 4 cycles, phasesel=sel, phasedir=0, phase 0 -> 1.
- At phase 0, one dec press -> phasedir=1, phase=63. A 2-cycle glitch on inc -> no step.
- sel=1: 3 inc presses -> channel 1 phase=3, channel 0 still 0. Presses while busy are dropped.
- Sweep with fail_in injected at positions 0-9 and 40-63 -> win_lo=10, win_len=30, final phase=24, sweep_done=1.
- Sweep with fail_in at every position -> sweep_fail=1, win_len=0, phase back to start, busy=0.
- rst_n low during STEP -> phasestep=0 immediately, phase=0, busy=0. After release the FSM is idle and the next press steps normally.
